// File: rtl/id_rf_issue_pkg.sv
// Shared constants, types and decode helper for the decode/operand-issue stage.
// The optional writeback bypass is enabled by defining ID_WB_BYPASS_EN.
package id_rf_issue_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int INST_WIDTH = 32;
  localparam int REG_AW     = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [REG_AW-1:0]     X0   = {REG_AW{1'b0}};

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     writer;
  } dec_t;

  // writer marks instructions that will retire through the writeback port
  function automatic dec_t decode(input logic [INST_WIDTH-1:0] inst);
    dec_t d;
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.rd     = inst[11:7];
    d.writer = (inst[6:0] == OPC_RTYPE) &&
               ((inst[31:25] == F7_BASE) || (inst[31:25] == F7_ALT));
    return d;
  endfunction

endpackage

// File: rtl/id_rf_issue_if.sv
// Fetch, execute and writeback signals of the issue stage bundled as one interface.
// slave = issue stage side, master = surrounding pipeline / bench side.
interface id_rf_issue_if;
  import id_rf_issue_pkg::*;

  logic [INST_WIDTH-1:0] inst_i;
  logic                  inst_valid_i;
  logic                  inst_ready_o;
  logic [DATA_WIDTH-1:0] op1_o;
  logic [DATA_WIDTH-1:0] op2_o;
  logic [INST_WIDTH-1:0] inst_o;
  logic                  ex_valid_o;
  logic                  ex_ready_i;
  logic                  wb_valid_i;
  logic [REG_AW-1:0]     wb_rd_i;
  logic                  wb_we_i;
  logic [DATA_WIDTH-1:0] wb_wdata_i;

  modport slave (
    input  inst_i, inst_valid_i, ex_ready_i,
    input  wb_valid_i, wb_rd_i, wb_we_i, wb_wdata_i,
    output inst_ready_o, op1_o, op2_o, inst_o, ex_valid_o
  );

  modport master (
    output inst_i, inst_valid_i, ex_ready_i,
    output wb_valid_i, wb_rd_i, wb_we_i, wb_wdata_i,
    input  inst_ready_o, op1_o, op2_o, inst_o, ex_valid_o
  );

endinterface

// File: rtl/id_rf_issue_regfile_2r1w.sv
// Integer register file: two asynchronous read ports, one synchronous write port, x0 reads 0.
// With ID_WB_BYPASS_EN a same-cycle write is forwarded to a matching read port.
module regfile_2r1w
  import id_rf_issue_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int NR = NUM_REGS,
  parameter int AW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  localparam logic [AW-1:0] IDX0 = {AW{1'b0}};

  logic [DW-1:0] mem_r [NR];

  // storage: cleared by reset, reset takes priority over a pending write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we && (waddr != IDX0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // read port A
  always_comb begin
    rdata_a = {DW{1'b0}};
    if (raddr_a == IDX0) begin
      rdata_a = {DW{1'b0}};
    end
`ifdef ID_WB_BYPASS_EN
    else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
`endif
    else begin
      rdata_a = mem_r[raddr_a];
    end
  end

  // read port B
  always_comb begin
    rdata_b = {DW{1'b0}};
    if (raddr_b == IDX0) begin
      rdata_b = {DW{1'b0}};
    end
`ifdef ID_WB_BYPASS_EN
    else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
`endif
    else begin
      rdata_b = mem_r[raddr_b];
    end
  end

endmodule

// File: rtl/id_rf_issue.sv
// Decode/operand-issue stage: busy scoreboard, register-file read and the output register to execute.
// Define ID_WB_BYPASS_EN to let a source retiring this cycle issue with the writeback data.
module id_rf_issue
  import id_rf_issue_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  id_rf_issue_if.slave bus
);

  dec_t                  dec_s;
  logic [NUM_REGS-1:0]   busy_r;
  logic [NUM_REGS-1:0]   busy_nxt_s;
  logic [DATA_WIDTH-1:0] rs1_data_s;
  logic [DATA_WIDTH-1:0] rs2_data_s;
  logic                  rs1_release_s;
  logic                  rs2_release_s;
  logic                  rs1_haz_s;
  logic                  rs2_haz_s;
  logic                  hazard_s;
  logic                  slot_free_s;
  logic                  ready_s;
  logic                  issue_s;
  logic                  rf_we_s;

  logic [DATA_WIDTH-1:0] op1_r;
  logic [DATA_WIDTH-1:0] op2_r;
  logic [INST_WIDTH-1:0] inst_r;
  logic                  ex_valid_r;

  assign dec_s = decode(bus.inst_i);

  assign rf_we_s = (bus.wb_valid_i && (bus.wb_we_i == WRITE_ENABLE) && (bus.wb_rd_i != X0))
                   ? WRITE_ENABLE : WRITE_DISABLE;

`ifdef ID_WB_BYPASS_EN
  assign rs1_release_s = bus.wb_valid_i && (bus.wb_rd_i == dec_s.rs1);
  assign rs2_release_s = bus.wb_valid_i && (bus.wb_rd_i == dec_s.rs2);
`else
  assign rs1_release_s = 1'b0;
  assign rs2_release_s = 1'b0;
`endif

  // RAW hazard per source; x0 is never busy
  always_comb begin
    rs1_haz_s = 1'b0;
    rs2_haz_s = 1'b0;
    if (dec_s.rs1 != X0) begin
      rs1_haz_s = busy_r[dec_s.rs1] && !rs1_release_s;
    end else begin
      rs1_haz_s = 1'b0;
    end
    if (dec_s.rs2 != X0) begin
      rs2_haz_s = busy_r[dec_s.rs2] && !rs2_release_s;
    end else begin
      rs2_haz_s = 1'b0;
    end
  end

  assign hazard_s    = rs1_haz_s || rs2_haz_s;
  assign slot_free_s = !ex_valid_r || bus.ex_ready_i;
  assign ready_s     = slot_free_s && !hazard_s;
  assign issue_s     = bus.inst_valid_i && ready_s;

  // scoreboard next state: retirement clears first so a same-cycle issue to that rd wins
  always_comb begin
    busy_nxt_s = busy_r;
    if (bus.wb_valid_i) begin
      busy_nxt_s[bus.wb_rd_i] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_s && dec_s.writer && (dec_s.rd != X0)) begin
      busy_nxt_s[dec_s.rd] = 1'b1;
    end else begin
      busy_nxt_s[X0] = 1'b0;
    end
    busy_nxt_s[X0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  regfile_2r1w #(
    .DW (DATA_WIDTH),
    .NR (NUM_REGS),
    .AW (REG_AW)
  ) u_regfile (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .we      (rf_we_s),
    .waddr   (bus.wb_rd_i),
    .wdata   (bus.wb_wdata_i),
    .raddr_a (dec_s.rs1),
    .rdata_a (rs1_data_s),
    .raddr_b (dec_s.rs2),
    .rdata_b (rs2_data_s)
  );

  // output register toward execute: load on issue, drain on consume, otherwise hold
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op1_r      <= ZERO;
      op2_r      <= ZERO;
      inst_r     <= {INST_WIDTH{1'b0}};
      ex_valid_r <= 1'b0;
    end else if (issue_s) begin
      op1_r      <= rs1_data_s;
      op2_r      <= rs2_data_s;
      inst_r     <= bus.inst_i;
      ex_valid_r <= 1'b1;
    end else if (bus.ex_ready_i) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  assign bus.inst_ready_o = ready_s;
  assign bus.op1_o        = op1_r;
  assign bus.op2_o        = op2_r;
  assign bus.inst_o       = inst_r;
  assign bus.ex_valid_o   = ex_valid_r;

endmodule

// File: tb/tb_id_rf_issue.sv
// Directed bench for id_rf_issue: issued vectors go to a scoreboard queue, a monitor checks
// each output consumed by execute; handshake/stall conditions are checked inline.
module tb_id_rf_issue;
  import id_rf_issue_pkg::*;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  id_rf_issue_if bus();

  id_rf_issue dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    logic [4:0] d, a, b;
    d = rd[4:0];
    a = rs1[4:0];
    b = rs2[4:0];
    return {f7, b, a, 3'b000, d, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one pop per output consumed by execute
  always @(negedge clk) begin
    if (rst_n && bus.ex_valid_o && bus.ex_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got op1=%h op2=%h inst=%h, none expected",
                 bus.op1_o, bus.op2_o, bus.inst_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.op1_o !== e.op1 || bus.op2_o !== e.op2 || bus.inst_o !== e.inst) begin
          n_err++;
          $display("FAIL issue_output: got op1=%h op2=%h inst=%h expected op1=%h op2=%h inst=%h",
                   bus.op1_o, bus.op2_o, bus.inst_o, e.op1, e.op2, e.inst);
        end
      end
    end
  end

  // starts and ends just after a rising edge
  task automatic wb(input int rd, input logic [31:0] data, input logic we);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = rd[4:0];
    bus.wb_we_i    = we;
    bus.wb_wdata_i = data;
    @(posedge clk); #1;
    bus.wb_valid_i = 1'b0;
    bus.wb_we_i    = 1'b0;
  endtask

  // present an instruction, expect acceptance after exp_wait stalled cycles
  task automatic issue(input logic [31:0] ins, input logic [31:0] e1, input logic [31:0] e2,
                       input int exp_wait);
    int waited;
    exp_t e;
    waited = 0;
    bus.inst_i       = ins;
    bus.inst_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.inst_ready_o && waited < 30) begin
      waited++;
      @(negedge clk);
    end
    check("issue_wait", waited, exp_wait);
    if (bus.inst_ready_o) begin
      e.op1 = e1; e.op2 = e2; e.inst = ins;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.inst_valid_i = 1'b0;
    bus.inst_i       = 32'h0000_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i_sub, i_x9;
    exp_t e;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.inst_i = 32'h0000_0000; bus.inst_valid_i = 1'b0; bus.ex_ready_i = 1'b1;
    bus.wb_valid_i = 1'b0; bus.wb_rd_i = 5'd0; bus.wb_we_i = 1'b0; bus.wb_wdata_i = 32'h0000_0000;

    // reset then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ex_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    check("rst_op1", bus.op1_o, 32'h0000_0000);
    check("rst_op2", bus.op2_o, 32'h0000_0000);
    check("rst_inst", bus.inst_o, 32'h0000_0000);
    check("rst_ready", {31'd0, bus.inst_ready_o}, 32'd1);
    @(posedge clk); #1;

    // writeback then read
    wb(5, 32'h1234_5678, 1'b1);
    issue(rtype(7'b0000000, 6, 5, 0), 32'h1234_5678, 32'h0000_0000, 0);
    wb(6, 32'hDEAD_BEEF, 1'b0);
    wb(1, 32'd11, 1'b1);
    wb(2, 32'd22, 1'b1);

    // RAW stall: add x7,x1,x2 then sub x8,x7,x1
    issue(rtype(7'b0000000, 7, 1, 2), 32'd11, 32'd22, 0);
    i_sub = rtype(7'b0100000, 8, 7, 1);
    bus.inst_i = i_sub;
    bus.inst_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("raw_stall", {31'd0, bus.inst_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd7; bus.wb_we_i = 1'b1; bus.wb_wdata_i = 32'd33;
    @(negedge clk);
`ifdef ID_WB_BYPASS_EN
    check("raw_wb_cycle_ready", {31'd0, bus.inst_ready_o}, 32'd1);
    e.op1 = 32'd33; e.op2 = 32'd11; e.inst = i_sub;
    if (bus.inst_ready_o) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.wb_valid_i = 1'b0; bus.wb_we_i = 1'b0; bus.inst_valid_i = 1'b0;
`else
    check("raw_wb_cycle_ready", {31'd0, bus.inst_ready_o}, 32'd0);
    @(posedge clk); #1;
    bus.wb_valid_i = 1'b0; bus.wb_we_i = 1'b0;
    @(negedge clk);
    check("raw_after_wb_ready", {31'd0, bus.inst_ready_o}, 32'd1);
    e.op1 = 32'd33; e.op2 = 32'd11; e.inst = i_sub;
    if (bus.inst_ready_o) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.inst_valid_i = 1'b0;
`endif
    bus.inst_i = 32'h0000_0000;
    wb(8, 32'd22, 1'b1);

    // backpressure: output held while execute stalls
    bus.ex_ready_i = 1'b0;
    i_x9 = rtype(7'b0000000, 9, 1, 2);
    issue(i_x9, 32'd11, 32'd22, 0);
    bus.inst_i = rtype(7'b0000000, 10, 2, 1);
    bus.inst_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.ex_valid_o}, 32'd1);
      check("bp_ready", {31'd0, bus.inst_ready_o}, 32'd0);
      check("bp_op1", bus.op1_o, 32'd11);
      check("bp_op2", bus.op2_o, 32'd22);
      check("bp_inst", bus.inst_o, i_x9);
    end
    @(posedge clk); #1;
    bus.ex_ready_i = 1'b1;
    issue(rtype(7'b0000000, 10, 2, 1), 32'd22, 32'd11, 0);
    wb(9, 32'h0000_0000, 1'b0);
    wb(10, 32'h0000_0000, 1'b0);

    // x0 rules
    wb(0, 32'hFFFF_FFFF, 1'b1);
    issue(rtype(7'b0000000, 11, 0, 1), 32'h0000_0000, 32'd11, 0);
    issue(rtype(7'b0000000, 0, 1, 2), 32'd11, 32'd22, 0);
    issue(rtype(7'b0000000, 12, 0, 0), 32'h0000_0000, 32'h0000_0000, 0);

    // reset mid-stall: x11 busy
    bus.inst_i = rtype(7'b0000000, 13, 11, 2);
    bus.inst_valid_i = 1'b1;
    @(negedge clk);
    check("pre_rst_stall", {31'd0, bus.inst_ready_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.inst_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ex_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    check("midrst_op1", bus.op1_o, 32'h0000_0000);
    issue(rtype(7'b0000000, 13, 11, 2), 32'h0000_0000, 32'h0000_0000, 0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
